// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
//   Instruction-fetch controller. It owns the fetch PC, issues word requests
//   to instruction memory over a req/ack handshake, and holds returned words
//   in a 2-entry {pc, word} buffer. The decode stage drains the buffer with
//   valid/ready. Branch/jump redirects reload the PC, flush the buffer and
//   discard any stale in-flight fetch.
//
// Parameters
//   RESET_PC : fetch address loaded on reset (bits [1:0] must be 0)
//   ADDR_W   : PC / address width (instruction width is fixed at 32)
//
// Ports
//   clock           system clock, rising edge
//   reset           asynchronous active-low reset
//   imem_req        fetch request to instruction memory
//   imem_addr       word-aligned fetch address, held until imem_ack
//   imem_ack        response strobe, imem_rdata valid this cycle
//   imem_rdata      instruction word from memory
//   redirect_valid  one-cycle redirect pulse
//   redirect_pc     redirect target (bits [1:0] ignored)
//   ins_valid       buffer head holds a valid instruction
//   ins_out         head instruction word
//   ins_pc          address of the head instruction
//   ins_ready       decode accepts the head (pop = ins_valid & ins_ready)
//   pc_out          current fetch PC (next address to request)
//
// Optional build macro
//   FETCH_PERF_EN   adds perf_fetched (pops) and perf_dropped (discarded
//                   responses), both 32-bit wrapping counters.
// ---------------------------------------------------------------------------
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned ADDR_W   = 32
) (
  input  logic              clock,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              ins_valid,
  output logic [31:0]       ins_out,
  output logic [ADDR_W-1:0] ins_pc,
  input  logic              ins_ready,
  output logic [ADDR_W-1:0] pc_out
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_dropped
`endif
);

  localparam logic [ADDR_W-1:0] L_RESET_PC = ADDR_W'(RESET_PC);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DROP
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [ADDR_W-1:0]   r_pc;
  logic [ADDR_W-1:0]   w_pc_nxt;
  logic [ADDR_W-1:0]   r_addr;
  logic [1:0]          r_cnt;

  logic [ADDR_W-1:0]   r_head_pc;
  logic [31:0]         r_head_word;
  logic [ADDR_W-1:0]   r_tail_pc;
  logic [31:0]         r_tail_word;

  logic                w_req;
  logic                w_pop;
  logic                w_push;
  logic                w_discard;
  logic [1:0]          w_cnt_after_pop;
  logic [ADDR_W-1:0]   w_redir_pc;

  assign w_pop           = ins_valid & ins_ready;
  assign w_cnt_after_pop = r_cnt - {1'b0, w_pop};
  assign w_redir_pc      = redirect_pc & ~ADDR_W'(3);

  // -------------------------------------------------------------------------
  // Next-state / control
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_req       = 1'b0;
    w_push      = 1'b0;
    w_discard   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (redirect_valid) begin
          w_pc_nxt    = w_redir_pc;
          w_state_nxt = S_IDLE;
        end else if (w_cnt_after_pop < 2'd2) begin
          w_state_nxt = S_FETCH;
        end
      end

      S_FETCH: begin
        w_req = 1'b1;
        if (imem_ack) begin
          if (redirect_valid) begin
            // Response arrives together with the redirect: it is stale.
            w_discard   = 1'b1;
            w_pc_nxt    = w_redir_pc;
            w_state_nxt = S_FETCH;
          end else begin
            w_push   = 1'b1;
            w_pc_nxt = r_pc + ADDR_W'(4);
            // Post push/pop occupancy is cnt_after_pop + 1; keep fetching
            // only while that leaves a free slot for the next response.
            w_state_nxt = (w_cnt_after_pop == 2'd0) ? S_FETCH : S_IDLE;
          end
        end else if (redirect_valid) begin
          w_pc_nxt    = w_redir_pc;
          w_state_nxt = S_DROP;
        end
      end

      S_DROP: begin
        w_req = 1'b1;
        if (redirect_valid) begin
          w_pc_nxt = w_redir_pc;
        end
        if (imem_ack) begin
          w_discard   = 1'b1;
          w_state_nxt = S_FETCH;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State, PC, request address and buffer
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_pc        <= L_RESET_PC;
      r_addr      <= L_RESET_PC;
      r_cnt       <= '0;
      r_head_pc   <= '0;
      r_head_word <= '0;
      r_tail_pc   <= '0;
      r_tail_word <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;

      // The request address tracks the PC, except while an abandoned request
      // is still outstanding: it must stay put until that ack arrives.
      if (w_state_nxt != S_DROP) begin
        r_addr <= w_pc_nxt;
      end

      if (redirect_valid) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= w_cnt_after_pop + {1'b0, w_push};
      end

      // Slot chosen by occupancy after this cycle's pop, so a push+pop at
      // count 1 lands directly in the head.
      if (w_push && (w_cnt_after_pop == 2'd0)) begin
        r_head_pc   <= r_addr;
        r_head_word <= imem_rdata;
      end else if (w_pop) begin
        r_head_pc   <= r_tail_pc;
        r_head_word <= r_tail_word;
      end

      if (w_push && (w_cnt_after_pop == 2'd1)) begin
        r_tail_pc   <= r_addr;
        r_tail_word <= imem_rdata;
      end
    end
  end

  assign imem_req  = w_req;
  assign imem_addr = r_addr;
  assign ins_valid = (r_cnt != 2'd0);
  assign ins_out   = r_head_word;
  assign ins_pc    = r_head_pc;
  assign pc_out    = r_pc;

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_dropped;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_perf_fetched <= '0;
      r_perf_dropped <= '0;
    end else begin
      if (w_pop) begin
        r_perf_fetched <= r_perf_fetched + 32'd1;
      end
      if (w_discard) begin
        r_perf_dropped <= r_perf_dropped + 32'd1;
      end
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_dropped = r_perf_dropped;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fetch_sequencer
//   Directed and randomized stimulus for fetch_sequencer, checked every cycle
//   against a queue-based reference model of the fetch front end.
// ---------------------------------------------------------------------------
module tb_fetch_sequencer;

  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam logic [31:0] K   = 32'hA5A5_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        ins_valid;
  logic [31:0] ins_out;
  logic [31:0] ins_pc;
  logic        ins_ready = 1'b0;
  logic [31:0] pc_out;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_dropped;
`endif

  fetch_sequencer #(
    .RESET_PC (RPC),
    .ADDR_W   (32)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ins_valid      (ins_valid),
    .ins_out        (ins_out),
    .ins_pc         (ins_pc),
    .ins_ready      (ins_ready),
    .pc_out         (pc_out)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_dropped   (perf_dropped)
`endif
  );

  always #5 clock = ~clock;

  // Reference model: buffered instructions, fetch PC, whether a request is
  // live this cycle, and whether that live request is an abandoned one.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] w;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc;
  logic [31:0] m_addr;
  bit          m_req;
  bit          m_stale;
  logic [31:0] m_fetched;
  logic [31:0] m_dropped;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  int unsigned g_lat    = 0;
  int unsigned g_wait   = 0;
  bit          g_ready  = 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pc      = RPC;
    m_addr    = RPC;
    m_req     = 1'b0;
    m_stale   = 1'b0;
    m_fetched = '0;
    m_dropped = '0;
    g_wait    = 0;
  endtask

  task automatic model_step(input bit redir, input logic [31:0] rpc,
                            input bit ack, input bit ready);
    bit pop;
    bit acked;
    pop   = (mq.size() != 0) && ready;
    acked = m_req && ack;
    if (pop) begin
      void'(mq.pop_front());
      m_fetched = m_fetched + 1;
    end
    if (acked && (m_stale || redir)) m_dropped = m_dropped + 1;
    if (acked && !m_stale && !redir) begin
      mq.push_back('{pc: m_addr, w: m_addr ^ K});
      m_pc = m_pc + 32'd4;
    end
    if (redir) begin
      mq.delete();
      m_pc = rpc & ~32'h3;
    end
    if (m_req && !acked) begin
      if (redir) m_stale = 1'b1;
    end else if (m_req) begin
      m_stale = 1'b0;
      m_req   = (mq.size() < 2);
      m_addr  = m_pc;
    end else begin
      m_req  = !redir && (mq.size() < 2);
      m_addr = m_pc;
    end
  endtask

  task automatic check_outputs();
    chk("imem_req", {31'b0, imem_req}, {31'b0, m_req});
    chk("imem_addr", imem_addr, m_addr);
    chk("pc_out", pc_out, m_pc);
    chk("ins_valid", {31'b0, ins_valid}, {31'b0, (mq.size() != 0)});
    if (mq.size() != 0) begin
      chk("ins_pc", ins_pc, mq[0].pc);
      chk("ins_out", ins_out, mq[0].w);
    end
`ifdef FETCH_PERF_EN
    chk("perf_fetched", perf_fetched, m_fetched);
    chk("perf_dropped", perf_dropped, m_dropped);
`endif
  endtask

  // One clock cycle: check at the negedge, drive, clock, advance the model.
  task automatic cyc(input bit redir, input logic [31:0] rpc);
    bit req_s;
    bit ack_s;
    check_outputs();
    req_s          = imem_req;
    ack_s          = req_s && (g_wait >= g_lat);
    imem_ack       = ack_s;
    imem_rdata     = imem_addr ^ K;
    ins_ready      = g_ready;
    redirect_valid = redir;
    redirect_pc    = rpc;
    @(posedge clock);
    if (ack_s) g_wait = 0;
    else if (req_s) g_wait++;
    model_step(redir, rpc, ack_s, g_ready);
    @(negedge clock);
    redirect_valid = 1'b0;
    imem_ack       = 1'b0;
  endtask

  // Asynchronous reset applied between clock edges; outputs must clear at once.
  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_valid", {31'b0, ins_valid}, 32'd0);
    chk("rst_pc_out", pc_out, RPC);
    chk("rst_addr", imem_addr, RPC);
    chk("rst_ins_out", ins_out, 32'd0);
    chk("rst_ins_pc", ins_pc, 32'd0);
    model_reset();
    imem_ack       = 1'b0;
    redirect_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic wait_req_addr(input logic [31:0] a);
    int k;
    k = 0;
    while (!(imem_req === 1'b1 && imem_addr === a) && k < 50) begin
      cyc(1'b0, '0);
      k++;
    end
    chk("wait_addr_timeout", {31'b0, (k < 50)}, 32'd1);
  endtask

  initial begin
    int first;
    int k;
    bit redir;
    logic [31:0] rpc;

    // Test 1: zero-wait memory, continuous stream
    g_lat = 0; g_ready = 1'b1;
    do_reset();
    first = -1;
    for (int i = 0; i < 12; i++) begin
      if (ins_valid === 1'b1 && first < 0) first = i;
      cyc(1'b0, '0);
    end
    chk("first_valid_cycle", first, 32'd2);

    // Test 2: stall with ins_ready low, then drain in order
    g_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 6; i++) cyc(1'b0, '0);
    chk("stall_pc", pc_out, 32'h8);
    chk("stall_req", {31'b0, imem_req}, 32'd0);
    chk("stall_head", ins_pc, 32'h0);
    g_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("drain_valid", {31'b0, ins_valid}, 32'd1);
      chk("drain_pc", ins_pc, 32'(i * 4));
      cyc(1'b0, '0);
    end
    for (int i = 0; i < 4; i++) cyc(1'b0, '0);

    // Test 3: slow memory, redirect while request for 0x8 is pending
    g_lat = 3;
    do_reset();
    wait_req_addr(32'h8);
    cyc(1'b0, '0);
    cyc(1'b1, 32'h100);
    chk("drop_req", {31'b0, imem_req}, 32'd1);
    chk("drop_addr", imem_addr, 32'h8);
    chk("drop_pc", pc_out, 32'h100);
    k = 0;
    while (ins_valid !== 1'b1 && k < 50) begin
      cyc(1'b0, '0);
      k++;
    end
    chk("drop_wait_timeout", {31'b0, (k < 50)}, 32'd1);
    chk("after_drop_pc", ins_pc, 32'h100);

    // Test 4: redirect coinciding with the ack for 0xC
    g_lat = 0;
    do_reset();
    wait_req_addr(32'hC);
    cyc(1'b1, 32'h200);
    chk("ackredir_req", {31'b0, imem_req}, 32'd1);
    chk("ackredir_addr", imem_addr, 32'h200);

    // Test 5: unaligned redirect target is word-aligned
    cyc(1'b1, 32'h0000_0103);
    chk("align_addr", imem_addr, 32'h100);

    // PC wrap past the top of the address space
    cyc(1'b1, 32'hFFFF_FFF8);
    for (int i = 0; i < 6; i++) cyc(1'b0, '0);

    // Test 6: reset while a request is outstanding and the buffer holds data
    g_lat = 3; g_ready = 1'b0;
    do_reset();
    k = 0;
    while (!(imem_req === 1'b1 && ins_valid === 1'b1) && k < 50) begin
      cyc(1'b0, '0);
      k++;
    end
    chk("midreq_timeout", {31'b0, (k < 50)}, 32'd1);
    do_reset();

    // Randomized traffic
    g_ready = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      g_lat   = $urandom_range(0, 3);
      g_ready = ($urandom_range(0, 3) != 0);
      redir   = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 2))
        0:       rpc = $urandom();
        1:       rpc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        default: rpc = 32'($urandom_range(0, 1023));
      endcase
      cyc(redir, rpc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
